mem_port_sched: RTL



---
 rtl/mem_port_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: arbitrates one data access and one instruction fetch
// onto a shared memory with fixed latency and freezes the pipeline until both are served.
module mem_port_sched #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_we,
  input  logic          d_rd,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic [DW-1:0] ld_rdata,
  output logic          d_done,
  output logic          stall,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          d_served_q, d_served_d;
  logic          i_served_q, i_served_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;

  logic dreq, d_pend, i_pend, d_cmpl, i_cmpl, stall_c;

  assign dreq    = d_we | d_rd;
  assign d_pend  = dreq & ~d_served_q;
  assign i_pend  = if_req & ~i_served_q;
  assign d_cmpl  = (state_q == DWAIT) && (cnt_q == 4'd0);
  assign i_cmpl  = (state_q == IWAIT) && (cnt_q == 4'd0);
  assign stall_c = (d_pend & ~d_cmpl) | (i_pend & ~i_cmpl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data access always wins arbitration in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d = DWAIT;
        end else if (i_pend) begin
          state_d = IWAIT;
        end else begin
          state_d = IDLE;
        end
      end
      DWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          state_d = DWAIT;
        end
      end
      IWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          state_d = IWAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          cnt_d       = LAT;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_pend) begin
          cnt_d      = LAT;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DWAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!mem_we_q) begin
          ld_rdata_d = mem_rdata;
        end else begin
          ld_rdata_d = ld_rdata_q;
        end
      end
      IWAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if_rdata_d = mem_rdata;
        end
      end
      default: cnt_d = 4'd0;
    endcase
    // An unstalled edge advances the pipeline, so served history is discarded.
    if (stall_c) begin
      d_served_d = d_served_q | d_cmpl;
      i_served_d = i_served_q | i_cmpl;
    end else begin
      d_served_d = 1'b0;
      i_served_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      d_served_q  <= 1'b0;
      i_served_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      d_served_q  <= d_served_d;
      i_served_q  <= i_served_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign d_done    = d_cmpl;
  assign if_done   = i_cmpl;
  assign stall     = stall_c;
  assign busy      = (state_q != IDLE);

endmodule
